shift_rows_seq: RTL

SHIFT_ROWS_SEQ -- requirements
Module: shift_rows_seq

---
 rtl/shift_rows_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/shift_rows_seq.sv
// AES round back-end: ShiftRows, then stream columns through an external
// one-cycle MixColumns unit and fold in the round key (or bypass for the final round).
module shift_rows_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         bypass_mix,
    output logic [31:0]  col_out,
    input  logic [31:0]  col_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   col_idx;
    logic [1:0]   cap_idx;
    logic         accept;
    logic         capture;
    logic [127:0] shifted;
    logic [127:0] shifted_q;
    logic [127:0] key_q;
    logic [127:0] result;

    // Row r rotates left by r columns.
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shifted[127 - 32*c - 8*r -: 8] = state_in[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        col_out   = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        cap_idx   = 2'd3;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = bypass_mix ? DONE : FEED;
                end
            end
            FEED: begin
                col_out = shifted_q[127 - 32*col_idx -: 32];
                // The mixer answers one cycle late, so column col_idx-1 arrives now.
                capture = (col_idx != 2'd0);
                cap_idx = col_idx - 2'd1;
                if (col_idx == 2'd3) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                capture   = 1'b1;
                cap_idx   = 2'd3;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx   <= '0;
            shifted_q <= '0;
            key_q     <= '0;
            result    <= '0;
        end else begin
            if (accept) begin
                shifted_q <= shifted;
                key_q     <= round_key;
                col_idx   <= '0;
                if (bypass_mix) begin
                    result <= shifted ^ round_key;
                end
            end else if (state == FEED) begin
                col_idx <= col_idx + 2'd1;
            end
            if (capture) begin
                result[127 - 32*cap_idx -: 32] <= col_in ^ key_q[127 - 32*cap_idx -: 32];
            end
        end
    end

    assign state_out = result;

endmodule
